// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-requester single-port RAM arbiter
//
// Arbitrates fetch (req[0]), load/store (req[1]) and loader (req[2]) onto a
// single RAM port. Each access runs IDLE -> ISSUE -> (WAIT x RAM_LAT -> RESP)
// for reads, IDLE -> ISSUE -> IDLE for writes.
//
// Parameters: ADDR_W (RAM word-address width), DATA_W (data width),
//             RAM_LAT (RAM read latency, 1..7 cycles).
// Ports:
//   clk, reset       clock, synchronous active-low reset
//   req, we          per-requester request / write enable
//   addr, wdata      packed per-requester address / write data
//   gnt, rvalid      one-hot grant pulse / read-response pulse
//   rdata            shared read data, valid with any rvalid bit
//   busy             high whenever not IDLE
//   ram_en, ram_we   RAM strobes, ram_addr/ram_wdata/ram_rdata RAM data path
// Optional feature: ARB_ROUND_ROBIN_EN alternates load/store and fetch
// (loader keeps top priority).

module mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int RAM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [3*ADDR_W-1:0]   addr,
    input  logic [3*DATA_W-1:0]   wdata,
    output logic [2:0]            gnt,
    output logic [2:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  busy,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state, state_nxt;
    logic [1:0]          win;
    logic [1:0]          pick;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [2:0]          cnt;
    logic [DATA_W-1:0]   rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 when load/store was the last of the two lower requesters granted;
    // reset points at fetch so load/store wins the first contest.
    logic                rr_last_ls;
`endif

    // Winner selection among the currently requesting sources.
    always_comb begin
        pick = 2'd0;
        if (req[2]) begin
            pick = 2'd2;
`ifdef ARB_ROUND_ROBIN_EN
        end else if (req[1] && req[0]) begin
            pick = rr_last_ls ? 2'd0 : 2'd1;
`endif
        end else if (req[1]) begin
            pick = 2'd1;
        end else begin
            pick = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            win       <= 2'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= 3'd0;
            rdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_ls <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (|req) begin
                        // Latch everything so later input changes cannot
                        // disturb the in-flight access.
                        win       <= pick;
                        lat_we    <= we[pick];
                        lat_addr  <= addr[pick*ADDR_W +: ADDR_W];
                        lat_wdata <= wdata[pick*DATA_W +: DATA_W];
`ifdef ARB_ROUND_ROBIN_EN
                        if (pick != 2'd2) begin
                            rr_last_ls <= (pick == 2'd1);
                        end
`endif
                    end
                end
                ISSUE: begin
                    cnt <= 3'(RAM_LAT - 1);
                end
                WAIT: begin
                    // The RAM data is valid during the last WAIT cycle.
                    if (cnt == 3'd0) begin
                        rdata_q <= ram_rdata;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        gnt       = 3'b000;
        rvalid    = 3'b000;
        ram_en    = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                gnt       = 3'b001 << win;
                ram_en    = 1'b1;
                state_nxt = lat_we ? IDLE : WAIT;
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rvalid    = 3'b001 << win;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ram_we    = ram_en & lat_we;
    assign ram_addr  = lat_addr;
    assign ram_wdata = lat_wdata;
    assign rdata     = rdata_q;
    assign busy      = (state != IDLE);

endmodule
